multiword_seq_adder: RTL and testbench
======================================

# multiword_seq_adder

Sequential multi-precision adder that sits around the 16-bit carry-lookahead adder stage. It latches two wide operands through a valid/ready handshake and feeds them to a 16-bit CLA slice one 16-bit chunk per cycle, least significant chunk first. It carries the chunk carry-out between cycles and presents the assembled sum, carry-out and signed-overflow flag through a valid/ready output handshake. Used wherever operand width exceeds 16 bits and area matters more than latency.

## Interface

Parameters:
- `WORDS`, default 4: number of 16-bit chunks. Operand width is `N = 16*WORDS`. Legal range 2..16.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and `cin` valid.
- `in_ready`  out  1  block can accept; `(state==IDLE) && !rst`.
- `a`  in  N  operand A.
- `b`  in  N  operand B.
- `cin`  in  1  carry-in to chunk 0.
- `sub`  in  1  subtract select; present only with `MWSA_SUB_EN`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  N  result.
- `cout`  out  1  carry out of bit N-1.
- `ovf`  out  1  signed two's-complement overflow.

## Operation

- FSM states: IDLE, ADD, DONE. Chunk index `idx` is a counter of width `$clog2(WORDS)`.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, latch `a`, `b` (and `sub`), and set `carry <= cin`, `idx <= 0`. Go to ADD.
  - `in_valid` without acceptance has no effect.
- ADD, one chunk per cycle:
  - Compute `{c, s} = a[idx] + b[idx] + carry` with the 16-bit CLA slice, using 4-bit groups with group generate/propagate.
  - Write `sum[16*idx +: 16] <= s` and `carry <= c`.
  - On `idx == WORDS-1`: register `cout <= c`, `ovf <= (a_msb == beff_msb) && (s[15] != a_msb)`, go to DONE. Otherwise `idx <= idx+1`.
- DONE:
  - `out_valid` = 1.
  - `sum`, `cout` and `ovf` are held stable until `out_valid && out_ready`, then go to IDLE.
  - `in_valid` is ignored; no overlap between operations.
- `sum` holds partial results during ADD and is only meaningful while `out_valid` = 1.
- Arithmetic is modulo 2^N. There is no saturation. `cout` is the unsigned carry.
- Reset values: state IDLE, `idx` 0, `carry` 0, `sum` 0, `cout` 0, `ovf` 0, `out_valid` 0. `in_ready` = 0 while `rst` is high and 1 in the first cycle after `rst` deasserts.
- Reset mid-operation (ADD or DONE) aborts the operation. The next cycle shows reset values, and no partial result is ever flagged valid.
- `rst` takes priority over any simultaneous handshake.

## Timing

- Accept at edge T.
- ADD occupies edges T+1 .. T+WORDS.
- `out_valid` rises in the cycle after edge T+WORDS, so latency is WORDS cycles from accept to `out_valid`.
- With `out_ready` held high, the result is consumed at edge T+WORDS+1. `in_ready` is high the following cycle and the next accept can occur at edge T+WORDS+2.
- Sustained throughput is one operation per WORDS+2 cycles.
- All outputs are registered except `in_ready`, which is decoded from state and `rst`.
- The combinational path is a single 16-bit CLA slice plus the carry register. There is no N-bit ripple.

## Configuration

- `MWSA_SUB_EN` defined:
  - Adds the `sub` port, latched on accept.
  - When `sub` = 1: `beff = ~b` and the initial carry is forced to 1 (`cin` is ignored), computing `a - b`. `cout` = 1 means no borrow. `ovf` uses `beff_msb`.
  - When `sub` = 0: behaviour is identical to the undefined case.
- `MWSA_SUB_EN` undefined: no `sub` port, `beff = b`, add only.

## Test plan

All scenarios use WORDS=4 (N=64).

- Single-chunk carry: `a` = 0x0000_0000_0000_FFFF, `b` = 1, `cin` = 0 -> `sum` = 0x0000_0000_0001_0000, `cout` 0, `ovf` 0. `out_valid` rises exactly 4 cycles after accept.
- Full carry chain: `a` = 0xFFFF_FFFF_FFFF_FFFF, `b` = 0, `cin` = 1 -> `sum` = 0, `cout` 1, `ovf` 0. The carry propagates across all 4 chunks.
- Signed overflow: `a` = 0x7FFF_FFFF_FFFF_FFFF, `b` = 1 -> `sum` = 0x8000_0000_0000_0000, `ovf` 1, `cout` 0.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE with `in_valid` = 1 -> `sum`/`cout`/`ovf` stable and `in_ready` 0. Raise `out_ready` -> IDLE next cycle. The next accept occurs at edge T+WORDS+2 relative to the previous accept.
- Reset mid-op: assert `rst` during the 2nd ADD cycle -> next cycle `out_valid` 0, `sum` 0, `cout` 0, `ovf` 0. `in_ready` 1 after `rst` drops. A following add of 3+4 returns 7.
- With `MWSA_SUB_EN`: `a` = 5, `b` = 7, `sub` = 1 -> `sum` = 0xFFFF_FFFF_FFFF_FFFE, `cout` 0, `ovf` 0. Then 7-5 -> `sum` 2, `cout` 1.

Source files
------------

// File: rtl/multiword_seq_adder_if.sv
// Handshake/bus bundle for multiword_seq_adder.
// Optional build macro: MWSA_SUB_EN adds the subtract-select signal.
interface multiword_seq_adder_if #(
  parameter int unsigned WORDS = 4
);
  localparam int unsigned N = 16 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
`ifdef MWSA_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

`ifdef MWSA_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif
endinterface

// File: rtl/multiword_seq_adder.sv
// Sequential multi-precision adder: one 16-bit CLA slice, one chunk per
// cycle, LSB chunk first, carry held in a register between chunks.
// Optional build macro: MWSA_SUB_EN enables a - b via the sub select.
module multiword_seq_adder #(
  parameter int unsigned WORDS = 4
) (
  input logic                 clk,
  input logic                 rst,
  multiword_seq_adder_if.slave bus
);
  localparam int unsigned CHUNK = 16;
  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t                       state;
  logic [IDX_W-1:0]             idx;
  logic                         carry;
  logic [WORDS-1:0][CHUNK-1:0]  a_q;
  logic [WORDS-1:0][CHUNK-1:0]  b_q;
  logic [WORDS-1:0][CHUNK-1:0]  sum_q;
  logic                         cout_q;
  logic                         ovf_q;
  logic                         out_valid_q;

  logic [CHUNK-1:0] op_a;
  logic [CHUNK-1:0] op_b;
  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [3:0]       gg;
  logic [3:0]       gp;
  logic [4:0]       gc;
  logic [CHUNK:0]   c;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;

  // 16-bit CLA slice on the current chunk: 4-bit groups with group G/P lookahead
  always_comb begin
    op_a = a_q[idx];
    op_b = b_q[idx];
    g    = op_a & op_b;
    p    = op_a ^ op_b;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = carry;
    gc[1] = gg[0] | (gp[0] & gc[0]);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) |
            (gp[2] & gp[1] & gp[0] & gc[0]);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
            (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k]   | (p[4*k]   & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])   | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k]) |
                 (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[CHUNK]   = gc[4];
    slice_sum  = p ^ c[CHUNK-1:0];
    slice_cout = gc[4];
  end

  // Control FSM and datapath registers; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            idx   <= '0;
`ifdef MWSA_SUB_EN
            // Subtract as a + ~b + 1; cin is ignored in that mode
            b_q   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
`else
            b_q   <= bus.b;
            carry <= bus.cin;
`endif
            state <= ADD;
          end
        end
        ADD: begin
          sum_q[idx] <= slice_sum;
          carry      <= slice_cout;
          if (idx == LAST_IDX) begin
            cout_q      <= slice_cout;
            ovf_q       <= (a_q[WORDS-1][CHUNK-1] == b_q[WORDS-1][CHUNK-1]) &&
                           (slice_sum[CHUNK-1] != a_q[WORDS-1][CHUNK-1]);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output drive; in_ready is the only decoded (unregistered) output
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_multiword_seq_adder.sv
// Directed self-checking bench for multiword_seq_adder (WORDS=4).
// Subtract vectors run only when MWSA_SUB_EN is defined.
module tb_multiword_seq_adder;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  multiword_seq_adder_if #(.WORDS(4)) bus ();

  multiword_seq_adder #(.WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation with out_ready high; check latency, result and release
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic [63:0] es, input logic ec,
                        input logic eo);
    int k;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'd4);
    check({tag, "_sum"}, bus.sum, es);
    check({tag, "_cout"}, 64'(bus.cout), 64'(ec));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
    tick();
    check({tag, "_released"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_ready_again"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int k;
    int pr;
    int acc[$];
    int d;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
`ifdef MWSA_SUB_EN
    bus.sub       = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", bus.sum, 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", 64'(bus.in_ready), 64'd1);
    tick();

    // Arithmetic vectors
    run_op("chunk_carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("full_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    run_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1);
    run_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'hEDCB_A987_6543_2110, 1'b1, 64'd1, 1'b1, 1'b0);

    // Backpressure: out_ready low for 5 cycles with in_valid held high
    bus.a         = 64'h1234_5678_9ABC_DEF0;
    bus.b         = 64'h1111_1111_1111_1111;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick();
      k++;
    end
    check("bp_latency", 64'(k), 64'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_sum", bus.sum, 64'h2345_6789_ABCD_F001);
      check("bp_hold_cout_ovf", {62'd0, bus.cout, bus.ovf}, 64'd0);
      check("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_hold_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_consumed_out_valid", 64'(bus.out_valid), 64'd0);
    check("bp_consumed_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_reaccept", 64'(bus.in_ready), 64'd0);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick();
      k++;
    end
    check("bp_second_latency", 64'(k), 64'd4);
    check("bp_second_sum", bus.sum, 64'h2345_6789_ABCD_F001);
    tick();

    // Throughput: in_valid and out_ready held high, accepts WORDS+2 edges apart
    bus.a         = 64'd10;
    bus.b         = 64'd20;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      pr = int'(bus.in_ready);
      tick();
      if (pr == 1) acc.push_back(e);
    end
    bus.in_valid = 1'b0;
    d = (acc.size() >= 2) ? (acc[1] - acc[0]) : -1;
    check("thru_accept_spacing", 64'(d), 64'd6);
    k = 0;
    while (!bus.in_ready && k < 20) begin
      tick();
      k++;
    end
    check("thru_drained", 64'(bus.in_ready), 64'd1);

    // Reset during the second ADD cycle
    bus.a         = 64'h1111_1111_1111_1111;
    bus.b         = 64'h2222_2222_2222_2222;
    bus.cin       = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_sum", bus.sum, 64'd0);
    check("midrst_cout", 64'(bus.cout), 64'd0);
    check("midrst_ovf", 64'(bus.ovf), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("midrst_release_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst_no_valid", 64'(bus.out_valid), 64'd0);
    end
    run_op("after_rst", 64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0);

`ifdef MWSA_SUB_EN
    // Subtraction: cin is ignored when sub is set
    bus.sub = 1'b1;
    run_op("sub_5m7", 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_7m5", 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0);
    run_op("sub_minneg", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    bus.sub = 1'b0;
    run_op("sub_off_add", 64'd5, 64'd7, 1'b1, 64'd13, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
